// File: rtl/fadd_issue_ctrl_pkg.sv
// Shared floating-point adder issue constants, rounding-mode encodings and operand payload.
package fadd_issue_ctrl_pkg;

    localparam int unsigned LAT_DEFAULT = 2;
    localparam int unsigned ID_W        = 1;
    localparam int unsigned FP_W        = 32;

    typedef logic [1:0] rm_t;

    localparam rm_t RM_NEAR = 2'b00;
    localparam rm_t RM_ZERO = 2'b01;
    localparam rm_t RM_UP   = 2'b10;
    localparam rm_t RM_DOWN = 2'b11;

    typedef struct packed {
        logic [FP_W-1:0] a;
        logic [FP_W-1:0] b;
        logic            sub;
        rm_t             rm;
    } fop_t;

endpackage

// File: rtl/fadd_issue_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; the priority pointer moves only when a grant is issued.
module rr_arb2 (
    input  logic       clk,
    input  logic       clrn,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o,
    output logic       gidx_o
);

    logic prio_q;
    logic prio_d;
    logic fire;

    always_comb begin
        gidx_o = 1'b0;
        gnt_o  = 2'b00;
        prio_d = prio_q;
        if (req_i == 2'b11) begin
            gidx_o = prio_q;
        end else if (req_i[1]) begin
            gidx_o = 1'b1;
        end
        fire = en_i & (|req_i);
        if (fire) begin
            gnt_o  = gidx_o ? 2'b10 : 2'b01;
            prio_d = ~gidx_o;
        end
    end

    // Pointer holds the index preferred on the next contended cycle.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/fadd_issue_ctrl.sv
// Issue controller sharing one pipelined FP adder between two requesters, with a
// valid/id shadow pipeline and a stall that freezes the adder on result backpressure.
module fadd_issue_ctrl
    import fadd_issue_ctrl_pkg::*;
#(
    parameter int unsigned LAT = LAT_DEFAULT
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [FP_W-1:0] req0_a,
    input  logic [FP_W-1:0] req0_b,
    input  logic            req0_sub,
    input  logic [1:0]      req0_rm,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [FP_W-1:0] req1_a,
    input  logic [FP_W-1:0] req1_b,
    input  logic            req1_sub,
    input  logic [1:0]      req1_rm,
    output logic [FP_W-1:0] fa,
    output logic [FP_W-1:0] fb,
    output logic            fsub,
    output logic [1:0]      frm,
    output logic            fe,
    input  logic [FP_W-1:0] fs,
    output logic            res_valid,
    input  logic            res_ready,
    output logic            res_id,
    output logic [FP_W-1:0] res_s,
    output logic            busy
);

    logic [LAT-1:0]           valid_q;
    logic [LAT-1:0]           valid_d;
    logic [LAT-1:0][ID_W-1:0] id_q;
    logic [LAT-1:0][ID_W-1:0] id_d;
    logic [1:0]               gnt;
    logic                     gidx;
    logic                     arb_en;
    fop_t                     op0;
    fop_t                     op1;
    fop_t                     op_sel;

    assign res_valid = valid_q[LAT-1];
    assign res_id    = id_q[LAT-1][0];
    assign res_s     = fs;
    assign busy      = |valid_q;
    assign fe        = ~(res_valid & ~res_ready);
    // Reset also blocks grants so no requester sees ready while clrn is low.
    assign arb_en    = fe & clrn;

    rr_arb2 u_arb (
        .clk    (clk),
        .clrn   (clrn),
        .req_i  ({req1_valid, req0_valid}),
        .en_i   (arb_en),
        .gnt_o  (gnt),
        .gidx_o (gidx)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    assign op0    = '{a: req0_a, b: req0_b, sub: req0_sub, rm: req0_rm};
    assign op1    = '{a: req1_a, b: req1_b, sub: req1_sub, rm: req1_rm};
    assign op_sel = gnt[1] ? op1 : op0;
    assign fa     = op_sel.a;
    assign fb     = op_sel.b;
    assign fsub   = op_sel.sub;
    assign frm    = op_sel.rm;

    always_comb begin
        valid_d    = valid_q;
        id_d       = id_q;
        valid_d[0] = |gnt;
        id_d[0]    = ID_W'(gidx);
        for (int unsigned i = 1; i < LAT; i++) begin
            valid_d[i] = valid_q[i-1];
            id_d[i]    = id_q[i-1];
        end
    end

    // Shadow pipeline advances in lockstep with the adder enable.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            valid_q <= '0;
            id_q    <= '0;
        end else if (fe) begin
            valid_q <= valid_d;
            id_q    <= id_d;
        end
    end

endmodule

// File: tb/tb_fadd_issue_ctrl.sv
// Directed bench for fadd_issue_ctrl driving a behavioural 2-stage FP adder model.
module tb_fadd_issue_ctrl;
    import fadd_issue_ctrl_pkg::*;

    localparam int unsigned LAT = 2;
    localparam logic [31:0] F1 = 32'h3F800000;
    localparam logic [31:0] F2 = 32'h40000000;
    localparam logic [31:0] F3 = 32'h40400000;
    localparam logic [31:0] F4 = 32'h40800000;
    localparam logic [31:0] F8 = 32'h41000000;

    logic        clk = 1'b0;
    logic        clrn;
    logic        req0_valid, req0_ready, req0_sub;
    logic [31:0] req0_a, req0_b;
    logic [1:0]  req0_rm;
    logic        req1_valid, req1_ready, req1_sub;
    logic [31:0] req1_a, req1_b;
    logic [1:0]  req1_rm;
    logic [31:0] fa, fb, fs, res_s;
    logic        fsub, fe, res_valid, res_ready, res_id, busy;
    logic [1:0]  frm;
    logic [31:0] pipe0, pipe1;

    int n_vec = 0;
    int n_bad = 0;
    int          exp_g[4] = '{0, 1, 0, 1};
    logic [31:0] exp_s[4] = '{F2, F3, F4, F8};

    always #5 clk = ~clk;

    fadd_issue_ctrl #(.LAT(LAT)) dut (
        .clk(clk), .clrn(clrn),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
        .req0_b(req0_b), .req0_sub(req0_sub), .req0_rm(req0_rm),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
        .req1_b(req1_b), .req1_sub(req1_sub), .req1_rm(req1_rm),
        .fa(fa), .fb(fb), .fsub(fsub), .frm(frm), .fe(fe), .fs(fs),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_s(res_s), .busy(busy)
    );

    function automatic real sp2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:0] == 31'd0) d = {f[31], 63'd0};
        else d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // Exact-value adder model with LAT pipeline stages gated by fe.
    always @(posedge clk) begin
        if (fe) begin
            pipe0 <= r2sp(fsub ? sp2r(fa) - sp2r(fb) : sp2r(fa) + sp2r(fb));
            pipe1 <= pipe0;
        end
    end
    assign fs = pipe1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_res(input string tag, input logic [31:0] id, input logic [31:0] s);
        check({tag, "_v"}, 32'(res_valid), 32'd1);
        check({tag, "_id"}, 32'(res_id), id);
        check({tag, "_s"}, res_s, s);
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic s);
        req0_valid = v; req0_a = a; req0_b = b; req0_sub = s;
    endtask

    task automatic drive1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic s);
        req1_valid = v; req1_a = a; req1_b = b; req1_sub = s;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, n_bad %0d", n_bad);
        $fatal(1);
    end

    initial begin
        clrn = 1'b0; res_ready = 1'b1;
        req0_rm = RM_NEAR; req1_rm = RM_ZERO;
        drive0(1'b1, F1, F1, 1'b0);
        drive1(1'b1, F1, F1, 1'b0);
        #4;
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready0", 32'(req0_ready), 32'd0);
        check("rst_ready1", 32'(req1_ready), 32'd0);
        check("rst_fe", 32'(fe), 32'd1);
        nxt;
        clrn = 1'b1;
        drive1(1'b0, F1, F1, 1'b0);

        // Single issue from requester 0: 1.0 + 2.0.
        drive0(1'b1, F1, F2, 1'b0);
        #4;
        check("one_ready0", 32'(req0_ready), 32'd1);
        check("one_fa", fa, F1);
        nxt;
        drive0(1'b0, 32'd0, 32'd0, 1'b0);
        #4;
        check("one_busy", 32'(busy), 32'd1);
        check("one_early", 32'(res_valid), 32'd0);
        nxt;
        #4;
        chk_res("one_res", 32'd0, F3);
        nxt;
        #4;
        check("one_drained", 32'(busy), 32'd0);
        nxt;

        // Subtraction through requester 1: 3.0 - 1.0.
        req1_rm = RM_NEAR;
        drive1(1'b1, F3, F1, 1'b1);
        #4;
        check("sub_ready1", 32'(req1_ready), 32'd1);
        check("sub_ready0", 32'(req0_ready), 32'd0);
        check("sub_fsub", 32'(fsub), 32'd1);
        check("sub_frm", 32'(frm), 32'(RM_NEAR));
        check("sub_fa", fa, F3);
        nxt;
        drive1(1'b0, 32'd0, 32'd0, 1'b0);
        nxt;
        #4;
        chk_res("sub_res", 32'd1, F2);
        nxt;

        // Contention: both requesters valid for four cycles.
        for (int c = 0; c < 6; c++) begin
            drive0(c < 4, (c < 2) ? F1 : F2, (c < 2) ? F1 : F2, 1'b0);
            drive1(c < 4, (c < 2) ? F1 : F4, (c < 2) ? F2 : F4, 1'b0);
            #4;
            if (c < 4) begin
                check("rr_gnt0", 32'(req0_ready), 32'(exp_g[c] == 0));
                check("rr_gnt1", 32'(req1_ready), 32'(exp_g[c] == 1));
            end
            if (c >= 2) chk_res("rr_res", 32'(exp_g[c-2]), exp_s[c-2]);
            nxt;
        end
        #4;
        check("rr_idle", 32'(busy), 32'd0);
        nxt;

        // Backpressure: three ops, result stalled for three cycles.
        for (int c = 0; c < 9; c++) begin
            drive0(c < 6, (c == 0) ? F1 : (c == 1) ? F2 : F4,
                          (c == 0) ? F1 : (c == 1) ? F2 : F4, 1'b0);
            res_ready = !(c >= 2 && c <= 4);
            #4;
            if (c < 2) check("bp_issue", 32'(req0_ready), 32'd1);
            if (c >= 2 && c <= 4) begin
                check("bp_fe", 32'(fe), 32'd0);
                check("bp_nogrant", 32'(req0_ready), 32'd0);
                check("bp_busy", 32'(busy), 32'd1);
                chk_res("bp_hold", 32'd0, F2);
            end
            if (c == 5) begin
                check("bp_release_grant", 32'(req0_ready), 32'd1);
                chk_res("bp_res0", 32'd0, F2);
            end
            if (c == 6) chk_res("bp_res1", 32'd0, F4);
            if (c == 7) chk_res("bp_res2", 32'd0, F8);
            if (c == 8) check("bp_done", 32'(res_valid | busy), 32'd0);
            nxt;
        end

        // Drain and issue in the same cycle.
        drive0(1'b1, F1, F1, 1'b0);
        nxt;
        drive0(1'b0, 32'd0, 32'd0, 1'b0);
        nxt;
        drive0(1'b1, F2, F2, 1'b0);
        #4;
        chk_res("di_res0", 32'd0, F2);
        check("di_grant", 32'(req0_ready), 32'd1);
        check("di_fe", 32'(fe), 32'd1);
        nxt;
        drive0(1'b0, 32'd0, 32'd0, 1'b0);
        #4;
        check("di_busy", 32'(busy), 32'd1);
        check("di_gap", 32'(res_valid), 32'd0);
        nxt;
        #4;
        chk_res("di_res1", 32'd0, F4);
        nxt;

        // Reset with two operations in flight.
        drive0(1'b1, F1, F1, 1'b0);
        nxt;
        drive0(1'b1, F2, F2, 1'b0);
        nxt;
        check("mr_pre_busy", 32'(busy), 32'd1);
        clrn = 1'b0;
        #3;
        check("mr_res_valid", 32'(res_valid), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_fe", 32'(fe), 32'd1);
        check("mr_ready0", 32'(req0_ready), 32'd0);
        nxt;
        clrn = 1'b1;
        drive0(1'b0, 32'd0, 32'd0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            #4;
            check("mr_stale", 32'(res_valid | busy), 32'd0);
            nxt;
        end
        drive0(1'b1, F1, F1, 1'b0);
        drive1(1'b1, F2, F2, 1'b0);
        #4;
        check("mr_prio0", 32'(req0_ready), 32'd1);
        check("mr_prio1", 32'(req1_ready), 32'd0);
        nxt;
        drive0(1'b0, 32'd0, 32'd0, 1'b0);
        drive1(1'b0, 32'd0, 32'd0, 1'b0);
        nxt;
        nxt;
        nxt;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
